// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider.
//   state_t : FSM state encoding (IDLE, CALC, DONE) used by divider.
// -----------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : divider_pkg

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One restoring-division step, purely combinational.
// Ports:
//   rem_in       [width:0]   partial remainder before the step (always < divisor)
//   dividend_bit             next dividend bit, taken MSB first
//   divisor      [width-1:0] divisor
//   rem_out      [width:0]   partial remainder after shift/compare/subtract
//   q_bit                    quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_step #(
  parameter int width = 8
) (
  input  logic [width:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [width-1:0] divisor,
  output logic [width:0]   rem_out,
  output logic             q_bit
);

  logic [width+1:0] shifted;
  logic [width:0]   diff;

  // rem_in < divisor < 2**width, so shifted never reaches bit width+1;
  // keeping that bit in the compare makes the step exact for any rem_in.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[width:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[width:0];
  end

endmodule : divider_step

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    request, accepted on a rising edge while ready=1
//   a, b        [width-1:0]  dividend / divisor, captured on acceptance
//   ready                    high in IDLE and DONE (a new start may be taken)
//   valid                    one-cycle pulse in DONE, results valid
//   q, r        [width-1:0]  quotient / remainder, held until the next result
//   div_by_zero              result came from b==0 (q=all ones, r=a)
// Latency: valid is seen width+1 edges after acceptance (1 edge when b==0).
// -----------------------------------------------------------------------------
module divider
  import divider_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             div_by_zero
);

  localparam int cnt_w = $clog2(width);

  state_t             state, state_next;
  logic [cnt_w-1:0]   cnt;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after width steps this register holds the quotient.
  logic [width-1:0]   work;
  logic [width-1:0]   divisor;
  logic [width:0]     rem, rem_next;
  logic               q_bit;
  logic               accept;
  logic               last_step;

  divider_step #(.width(width)) u_step (
    .rem_in       (rem),
    .dividend_bit (work[width-1]),
    .divisor      (divisor),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  assign last_step = (cnt == '0);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    valid      = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        ready  = 1'b1;
        valid  = (state == DONE);
        accept = start;
        if (start)              state_next = (b == '0) ? DONE : CALC;
        else                    state_next = IDLE;
      end
      CALC: begin
        if (last_step)          state_next = DONE;
      end
      default:                  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the working registers are reset as well as the visible outputs, so
  // an operation aborted by reset leaves no residue for the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      work        <= '0;
      divisor     <= '0;
      rem         <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt     <= cnt_w'(width - 1);
      work    <= a;
      divisor <= b;
      rem     <= '0;
      if (b == '0) begin
        q           <= '1;
        r           <= a;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      work <= {work[width-2:0], q_bit};
      rem  <= rem_next;
      if (last_step) begin
        q           <= {work[width-2:0], q_bit};
        r           <= rem_next[width-1:0];
        div_by_zero <= 1'b0;
      end else begin
        cnt <= cnt - cnt_w'(1);
      end
    end
  end

endmodule : divider

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Scoreboard bench for divider (width=8). The driver pushes the expected
// result and its due edge when it issues a start; the monitor pops and
// compares on every valid pulse.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int w = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [w-1:0] a     = '0;
  logic [w-1:0] b     = '0;
  logic         ready;
  logic         valid;
  logic [w-1:0] q;
  logic [w-1:0] r;
  logic         div_by_zero;

  typedef struct {
    logic [w-1:0] q;
    logic [w-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  divider #(.width(w)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .valid       (valid),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: results are sampled on the falling edge, away from the DUT edge.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", 32'(q), 32'(e.q));
        check("r", 32'(r), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        check("latency_edge", 32'(cyc + 1), 32'(e.due));
      end
    end
  end

  // Issue one operation; returns on the falling edge after the acceptance edge.
  task automatic do_op(input logic [w-1:0] av, input logic [w-1:0] bv,
                       input logic [w-1:0] eq, input logic [w-1:0] er,
                       input logic edbz);
    exp_t e;
    int   n = 0;
    while (!ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    start = 1'b1;
    a     = av;
    b     = bv;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.due = cyc + 1 + ((bv == '0) ? 1 : w + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  s;
    logic [w-1:0] av, bv;

    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_q", 32'(q), 32'd0);
    check("reset_r", 32'(r), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 200 / 7 with start pulses while busy; ready must stay low in CALC.
    do_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check("ready_in_calc", 32'(ready), 32'd0);
      start = (i % 2 == 0);
      a     = 8'd9;
      b     = 8'd2;
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // Divide by zero, then a normal small result.
    do_op(8'd5, 8'd0, 8'd255, 8'd5, 1'b1);
    do_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
    drain();

    // Back-to-back: second start taken in DONE of the first.
    do_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    do_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    drain();

    // Results hold while idle.
    repeat (5) @(negedge clk);
    check("hold_q", 32'(q), 32'd1);
    check("hold_r", 32'(r), 32'd0);
    check("hold_dbz", 32'(div_by_zero), 32'd0);
    check("hold_valid", 32'(valid), 32'd0);

    // Reset after four CALC steps aborts the operation.
    do_op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_q", 32'(q), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0);
    drain();

    // Xorshift operand pairs against a behavioural model.
    s = 32'h2545_F491;
    for (int i = 0; i < 200; i++) begin
      s  = s ^ (s << 13);
      s  = s ^ (s >> 17);
      s  = s ^ (s << 5);
      av = s[7:0];
      bv = (i % 10 == 0) ? 8'd0 : s[15:8];
      if (bv == '0) do_op(av, bv, 8'hFF, av, 1'b1);
      else          do_op(av, bv, av / bv, av % bv, 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_divider
